// File: rtl/multi_credit_counter.sv
// Multi-channel credit counter with saturating per-channel pools and registered ready/valid.
// Define CREDIT_COUNTER_CHECK_EN to add the sticky o_credit_error overflow flags.
module multi_credit_counter #(
  parameter int N_CHANNELS      = 4,
  parameter int N_CREDITS       = 10,
  parameter int RETURN_WIDTH    = 2,
  parameter int READY_THRESHOLD = 1,
  localparam int CW             = $clog2(N_CREDITS + 1)
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [N_CHANNELS-1:0]            i_fifo_empty,
  input  logic [N_CHANNELS*RETURN_WIDTH-1:0] i_credit_return,
  output logic [N_CHANNELS-1:0]            o_ready,
  output logic [N_CHANNELS-1:0]            o_valid,
  output logic [N_CHANNELS*CW-1:0]         o_credit_count
`ifdef CREDIT_COUNTER_CHECK_EN
  ,
  output logic [N_CHANNELS-1:0]            o_credit_error
`endif
);

  // Sum is wide enough to hold a full count plus a maximum return without wrapping.
  localparam int SW = CW + RETURN_WIDTH;

  logic [N_CHANNELS-1:0][CW-1:0] count_q, count_d;
  logic [N_CHANNELS-1:0][SW-1:0] sum;
  logic [N_CHANNELS-1:0]         consume;
  logic [N_CHANNELS-1:0]         overflow;
  logic [N_CHANNELS-1:0]         ready_q, ready_d;
  logic [N_CHANNELS-1:0]         valid_q, valid_d;

  always_comb begin
    count_d  = count_q;
    sum      = '0;
    consume  = '0;
    overflow = '0;
    ready_d  = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      // The non-zero gate is what protects against the one-cycle ready lag.
      consume[c]  = !i_fifo_empty[c] && (count_q[c] != '0);
      sum[c]      = SW'(count_q[c])
                  + SW'(i_credit_return[c*RETURN_WIDTH +: RETURN_WIDTH])
                  - SW'(consume[c]);
      overflow[c] = sum[c] > SW'(N_CREDITS);
      count_d[c]  = overflow[c] ? CW'(N_CREDITS) : sum[c][CW-1:0];
      ready_d[c]  = count_q[c] >= CW'(READY_THRESHOLD);
    end
    valid_d = consume;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        count_q[c] <= CW'(N_CREDITS);
      end
      ready_q <= '0;
      valid_q <= '0;
    end else begin
      count_q <= count_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign o_ready        = ready_q;
  assign o_valid        = valid_q;
  assign o_credit_count = count_q;

`ifdef CREDIT_COUNTER_CHECK_EN
  logic [N_CHANNELS-1:0] error_q, error_d;

  always_comb begin
    error_d = error_q | overflow;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      error_q <= '0;
    end else begin
      error_q <= error_d;
    end
  end

  assign o_credit_error = error_q;

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (reset_n) begin
      assert (overflow == '0)
        else $warning("credit overflow on channels %b", overflow);
    end
  end
`endif
`endif

endmodule
